// File: rtl/instr_register_alu.sv
// instr_register_alu
//   Register file of DEPTH entries, each holding {opcode, operand_a, operand_b,
//   result, err}. The result is produced by an internal signed ALU when the
//   entry is loaded. Reads are registered and answer with a one-cycle rd_valid
//   pulse.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   load_en, opcode,          write strobe, operation and signed operands
//   operand_a, operand_b
//   write_pointer             write address (ignored when auto-pointer build)
//   read_en, read_pointer     read strobe and address
//   rd_valid                  one-cycle pulse after a read
//   rd_opcode, rd_operand_a,  stored entry fields (held while read_en=0)
//   rd_operand_b, rd_result
//   rd_err                    entry unwritten, or its result flagged in error
//
// Build option
//   INSTR_REG_AUTO_PTR_EN     when defined, writes go to an internal wrapping
//                             counter instead of write_pointer.
module instr_register_alu #(
  parameter int OP_WIDTH  = 32,
  parameter int DEPTH     = 32,
  parameter int RES_WIDTH = 64,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        load_en,
  input  logic signed [OP_WIDTH-1:0]  operand_a,
  input  logic signed [OP_WIDTH-1:0]  operand_b,
  input  logic [3:0]                  opcode,
  input  logic [AW-1:0]               write_pointer,
  input  logic                        read_en,
  input  logic [AW-1:0]               read_pointer,
  output logic                        rd_valid,
  output logic [3:0]                  rd_opcode,
  output logic [OP_WIDTH-1:0]         rd_operand_a,
  output logic [OP_WIDTH-1:0]         rd_operand_b,
  output logic [RES_WIDTH-1:0]        rd_result,
  output logic                        rd_err
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_register_alu: DEPTH must be a power of 2 and >= 2");
  end
  if (RES_WIDTH < 2 * OP_WIDTH) begin : g_bad_res
    $error("instr_register_alu: RES_WIDTH must be >= 2*OP_WIDTH");
  end

  typedef enum logic [3:0] {
    OP_ZERO  = 4'd0,
    OP_PASSA = 4'd1,
    OP_PASSB = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_MULT  = 4'd5,
    OP_DIV   = 4'd6,
    OP_MOD   = 4'd7
  } op_e;

  typedef struct packed {
    logic [3:0]           opcode;
    logic [OP_WIDTH-1:0]  a;
    logic [OP_WIDTH-1:0]  b;
    logic [RES_WIDTH-1:0] result;
    logic                 err;
  } entry_t;

  // ---------------------------------------------------------------- ALU
  // Operands are widened before the operation so the product is exact and
  // the one overflowing quotient (most-negative / -1) is still representable.
  logic signed [RES_WIDTH-1:0] sa, sb;
  logic signed [RES_WIDTH-1:0] alu_res;
  logic                        alu_err;

  assign sa = {{(RES_WIDTH-OP_WIDTH){operand_a[OP_WIDTH-1]}}, operand_a};
  assign sb = {{(RES_WIDTH-OP_WIDTH){operand_b[OP_WIDTH-1]}}, operand_b};

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (opcode)
      OP_ZERO:  alu_res = '0;
      OP_PASSA: alu_res = sa;
      OP_PASSB: alu_res = sb;
      OP_ADD:   alu_res = sa + sb;
      OP_SUB:   alu_res = sa - sb;
      OP_MULT:  alu_res = sa * sb;
      OP_DIV: begin
        if (operand_b == '0) alu_err = 1'b1;
        else                 alu_res = sa / sb;
      end
      OP_MOD: begin
        if (operand_b == '0) alu_err = 1'b1;
        else                 alu_res = sa % sb;
      end
      default:  alu_err = 1'b1;
    endcase
  end

  entry_t new_entry;
  always_comb begin
    new_entry        = '0;
    new_entry.opcode = opcode;
    new_entry.a      = operand_a;
    new_entry.b      = operand_b;
    new_entry.result = alu_res;
    new_entry.err    = alu_err;
  end

  // ---------------------------------------------------------------- write address
  logic [AW-1:0] wptr;

`ifdef INSTR_REG_AUTO_PTR_EN
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic          unused_wp;

  // DEPTH is a power of 2, so the natural AW-bit wrap overwrites the oldest entry.
  assign wcnt_d    = load_en ? wcnt_q + AW'(1) : wcnt_q;
  assign wptr      = wcnt_q;
  assign unused_wp = ^write_pointer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wcnt_q <= '0;
    else          wcnt_q <= wcnt_d;
  end
`else
  assign wptr = write_pointer;
`endif

  // ---------------------------------------------------------------- storage
  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic   [DEPTH-1:0] wr_q, wr_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    if (load_en) begin
      mem_d[wptr] = new_entry;
      wr_d[wptr]  = 1'b1;
    end
  end

  // ---------------------------------------------------------------- read port
  entry_t rd_q, rd_d;
  logic   rd_valid_q, rd_valid_d;

  always_comb begin
    rd_valid_d = read_en;
    rd_d       = rd_q;
    if (read_en) begin
      // Same-cycle write to the read address is forwarded straight from the ALU.
      if (load_en && wptr == read_pointer) begin
        rd_d = new_entry;
      end else if (wr_q[read_pointer]) begin
        rd_d = mem_q[read_pointer];
      end else begin
        rd_d     = '0;
        rd_d.err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_valid     = rd_valid_q;
  assign rd_opcode    = rd_q.opcode;
  assign rd_operand_a = rd_q.a;
  assign rd_operand_b = rd_q.b;
  assign rd_result    = rd_q.result;
  assign rd_err       = rd_q.err;

endmodule

// File: tb/tb_instr_register_alu.sv
// Self-checking bench for instr_register_alu (default parameters).
// Expected read responses are queued when a read is issued and popped and
// compared once the registered response is visible.
module tb_instr_register_alu;

  localparam int OPW   = 32;
  localparam int DEPTH = 32;
  localparam int RESW  = 64;
  localparam int AW    = 5;

  typedef struct {
    logic [3:0]      op;
    logic [OPW-1:0]  a;
    logic [OPW-1:0]  b;
    logic [RESW-1:0] res;
    logic            err;
  } exp_t;

  typedef logic [1+1+4+OPW+OPW+RESW-1:0] rdv_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            load_en = 1'b0;
  logic [OPW-1:0]  operand_a = '0;
  logic [OPW-1:0]  operand_b = '0;
  logic [3:0]      opcode = '0;
  logic [AW-1:0]   write_pointer = '0;
  logic            read_en = 1'b0;
  logic [AW-1:0]   read_pointer = '0;
  logic            rd_valid;
  logic [3:0]      rd_opcode;
  logic [OPW-1:0]  rd_operand_a;
  logic [OPW-1:0]  rd_operand_b;
  logic [RESW-1:0] rd_result;
  logic            rd_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  instr_register_alu #(.OP_WIDTH(OPW), .DEPTH(DEPTH), .RES_WIDTH(RESW)) dut (
    .clk(clk), .reset_n(reset_n), .load_en(load_en),
    .operand_a(operand_a), .operand_b(operand_b), .opcode(opcode),
    .write_pointer(write_pointer), .read_en(read_en), .read_pointer(read_pointer),
    .rd_valid(rd_valid), .rd_opcode(rd_opcode), .rd_operand_a(rd_operand_a),
    .rd_operand_b(rd_operand_b), .rd_result(rd_result), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  function automatic rdv_t rd_now();
    return {rd_valid, rd_err, rd_opcode, rd_operand_a, rd_operand_b, rd_result};
  endfunction

  function automatic rdv_t want(exp_t e);
    return {1'b1, e.err, e.op, e.a, e.b, e.res};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] op, input logic [OPW-1:0] a,
                      input logic [OPW-1:0] b, input logic [AW-1:0] wp);
    load_en = 1'b1; opcode = op; operand_a = a; operand_b = b; write_pointer = wp;
  endtask

  task automatic do_reset();
    load_en = 1'b0; read_en = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // Reset state, then every entry must read back as unwritten.
  task automatic test_reset();
    exp_t e;
    rdv_t got;
    #2;
    reset_n = 1'b0;
    #2;
    n_checks++;
    if (rd_now() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", rd_now());
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      read_en = 1'b1; read_pointer = AW'(i);
      sb.push_back('{4'd0, '0, '0, '0, 1'b1});
      tick();
      e = sb.pop_front();
      got = rd_now();
      n_checks++;
      if (got !== want(e)) begin
        n_fail++;
        $display("FAIL unwritten_read[%0d]: got %h want %h", i, got, want(e));
      end
    end
    read_en = 1'b0;
  endtask

  // All opcodes including divide-by-zero and reserved.
  task automatic test_alu();
    exp_t tbl [0:11];
    exp_t e;
    rdv_t got;
    logic [AW-1:0] addr;
    tbl = '{
      '{4'd3, -5,           12,  7,                        1'b0},
      '{4'd5, 32'h7FFFFFFF, 2,   64'h00000000FFFFFFFE,     1'b0},
      '{4'd6, -7,           2,   -3,                       1'b0},
      '{4'd7, -7,           2,   -1,                       1'b0},
      '{4'd6, 9,            0,   0,                        1'b1},
      '{4'hB, 3,            4,   0,                        1'b1},
      '{4'd4, 3,            10,  -7,                       1'b0},
      '{4'd1, -1,           5,   -1,                       1'b0},
      '{4'd2, 8,            -9,  -9,                       1'b0},
      '{4'd0, 8,            9,   0,                        1'b0},
      '{4'd6, 32'h80000000, -1,  64'h0000000080000000,     1'b0},
      '{4'd5, -3,           4,   -12,                      1'b0}
    };
    for (int i = 0; i < 12; i++) begin
      addr = (i == 0) ? AW'(3) : AW'(9 + i);
      load(tbl[i].op, tbl[i].a, tbl[i].b, addr);
      tick();
    end
    load_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      addr = (i == 0) ? AW'(3) : AW'(9 + i);
      read_en = 1'b1; read_pointer = addr;
      sb.push_back(tbl[i]);
      tick();
      e = sb.pop_front();
      got = rd_now();
      n_checks++;
      if (got !== want(e)) begin
        n_fail++;
        $display("FAIL alu[%0d] op=%h: got %h want %h", i, e.op, got, want(e));
      end
    end
    read_en = 1'b0;
  endtask

  // Same-cycle load and read of address 5, then hold with read_en low.
  task automatic test_bypass();
    exp_t e;
    rdv_t got;
    rdv_t hold;
    load(4'd4, 10, 4, AW'(5));
    read_en = 1'b1; read_pointer = AW'(5);
    sb.push_back('{4'd4, 10, 4, 6, 1'b0});
    tick();
    e = sb.pop_front();
    got = rd_now();
    n_checks++;
    if (got !== want(e)) begin
      n_fail++;
      $display("FAIL bypass: got %h want %h", got, want(e));
    end
    load_en = 1'b0; read_en = 1'b0; read_pointer = AW'(0);
    tick();
    hold = {1'b0, 1'b0, 4'd4, 32'd10, 32'd4, 64'd6};
    got = rd_now();
    n_checks++;
    if (got !== hold) begin
      n_fail++;
      $display("FAIL read_idle_hold: got %h want %h", got, hold);
    end
  endtask

  // Write every cycle while reading the previous cycle's write.
  task automatic test_back_to_back();
    exp_t prev;
    exp_t e;
    exp_t cur;
    rdv_t got;
    logic [AW-1:0] prev_addr;
    prev = '{4'd0, '0, '0, '0, 1'b0};
    prev_addr = '0;
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) begin
        cur.op  = (k % 2) ? 4'd4 : 4'd3;
        cur.a   = $urandom;
        cur.b   = $urandom;
        cur.res = (k % 2) ? longint'(signed'(cur.a)) - longint'(signed'(cur.b))
                          : longint'(signed'(cur.a)) + longint'(signed'(cur.b));
        cur.err = 1'b0;
        load(cur.op, cur.a, cur.b, AW'(16 + k));
      end else begin
        load_en = 1'b0;
      end
      read_en = (k > 0);
      read_pointer = prev_addr;
      if (k > 0) sb.push_back(prev);
      tick();
      if (k > 0) begin
        e = sb.pop_front();
        got = rd_now();
        n_checks++;
        if (got !== want(e)) begin
          n_fail++;
          $display("FAIL b2b[%0d]: got %h want %h", k, got, want(e));
        end
      end
      prev = cur;
      prev_addr = AW'(16 + k);
    end
    read_en = 1'b0;
  endtask

`ifdef INSTR_REG_AUTO_PTR_EN
  // write_pointer is ignored; the counter wraps and overwrites entry 0.
  task automatic test_auto_ptr();
    exp_t e;
    rdv_t got;
    int   addrs [0:2];
    int   vals  [0:2];
    do_reset();
    for (int k = 0; k <= DEPTH; k++) begin
      load(4'd1, OPW'(k), '0, AW'(7));
      tick();
    end
    load_en = 1'b0;
    addrs = '{0, 1, 7};
    vals  = '{DEPTH, 1, 7};
    for (int i = 0; i < 3; i++) begin
      read_en = 1'b1; read_pointer = AW'(addrs[i]);
      sb.push_back('{4'd1, OPW'(vals[i]), '0, RESW'(vals[i]), 1'b0});
      tick();
      e = sb.pop_front();
      got = rd_now();
      n_checks++;
      if (got !== want(e)) begin
        n_fail++;
        $display("FAIL auto_ptr[addr %0d]: got %h want %h", addrs[i], got, want(e));
      end
    end
    read_en = 1'b0;
  endtask
`endif

  // Reset asserted while a read response is pending and a load is in flight.
  task automatic test_reset_mid();
    exp_t e;
    rdv_t got;
    read_en = 1'b1; read_pointer = AW'(1);
    tick();
    n_checks++;
    if (rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_valid: got %b want 1", rd_valid);
    end
    load(4'd3, 1, 1, AW'(9));
    read_en = 1'b1; read_pointer = AW'(9);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (rd_now() !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h want 0", rd_now());
    end
    tick();
    load_en = 1'b0; read_en = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      read_en = 1'b1; read_pointer = AW'(i);
      sb.push_back('{4'd0, '0, '0, '0, 1'b1});
      tick();
      e = sb.pop_front();
      got = rd_now();
      n_checks++;
      if (got !== want(e)) begin
        n_fail++;
        $display("FAIL post_reset_read[%0d]: got %h want %h", i, got, want(e));
      end
    end
    read_en = 1'b0;
  endtask

  initial begin
    test_reset();
`ifdef INSTR_REG_AUTO_PTR_EN
    test_auto_ptr();
`else
    test_alu();
    test_bypass();
    test_back_to_back();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
